// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and width helpers for the HI/LO multiply/divide sequencer.
// The multiply-accumulate ops are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int unsigned OpWidth = 4;

  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StWb
  } mdu_state_e;

  // Counter must hold DATA_WIDTH for the divide sign-fix cycle.
  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

  function automatic logic is_mul_op(input logic [OpWidth-1:0] op);
`ifdef MDU_MADD_EN
    return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
`else
    return op inside {OpMult, OpMultu};
`endif
  endfunction

  function automatic logic is_div_op(input logic [OpWidth-1:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

  function automatic logic is_mt_op(input logic [OpWidth-1:0] op);
    return op inside {OpMthi, OpMtlo};
  endfunction

  function automatic logic is_signed_op(input logic [OpWidth-1:0] op);
    return op inside {OpMult, OpDiv, OpMadd, OpMsub};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial remainder and
// subtract the divisor when it fits, shifting the resulting quotient bit in.
module mdu_div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] div_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0] trial;
  logic [DATA_WIDTH:0] diff;
  logic                fits;

  assign trial = {rem_i, quo_i[DATA_WIDTH-1]};
  assign fits  = trial >= {1'b0, div_i};
  assign diff  = trial - {1'b0, div_i};

  always_comb begin
    rem_o = fits ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    quo_o = {quo_i[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer owning the register file write port.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module hilo_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OpWidth-1:0]    op,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  output logic                  busy,
  output logic                  done,
  output logic                  hilo_we,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned CntW = cnt_width(DATA_WIDTH);

  mdu_state_e         state_q, state_d;
  logic [OpWidth-1:0] op_q, op_d;
  logic [DW-1:0]      a_q, a_d, b_q, b_d;
  logic [DW-1:0]      rem_q, rem_d, quo_q, quo_d;
  logic [DW-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               done_q, done_d, wb_q, wb_d;
`ifdef MDU_MADD_EN
  logic [DW-1:0]      acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
`endif

  logic          op_signed, a_neg, b_neg, accept;
  logic [DW-1:0] dvs_mag, step_rem, step_quo;
  logic [2*DW-1:0] mul_a, mul_b, product, mul_res;

  assign op_signed = is_signed_op(op_q);
  assign a_neg     = op_signed & a_q[DW-1];
  assign b_neg     = op_signed & b_q[DW-1];
  assign dvs_mag   = b_neg ? -b_q : b_q;

  // Extending to full width first makes the low 2*DW bits of the product correct either way.
  assign mul_a   = op_signed ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
  assign mul_b   = op_signed ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
  assign product = mul_a * mul_b;

`ifdef MDU_MADD_EN
  always_comb begin
    mul_res = product;
    case (op_q)
      OpMadd, OpMaddu: mul_res = {acc_hi_q, acc_lo_q} + product;
      OpMsub, OpMsubu: mul_res = {acc_hi_q, acc_lo_q} - product;
      default:         mul_res = product;
    endcase
  end
`else
  assign mul_res = product;
`endif

  mdu_div_step #(
    .DATA_WIDTH(DW)
  ) u_div_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(dvs_mag),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  assign accept  = start & ~flush & (state_q == StIdle)
                 & (is_mul_op(op) | is_div_op(op) | is_mt_op(op));
  assign busy    = (state_q == StMul) | (state_q == StDiv)
                 | (start & (state_q == StIdle) & (is_mul_op(op) | is_div_op(op)));
  assign hilo_we = wb_q & ~flush;
  assign done    = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wb_d    = 1'b0;
`ifdef MDU_MADD_EN
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
`endif
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_d = op;
            a_d  = src_a;
            b_d  = src_b;
`ifdef MDU_MADD_EN
            acc_hi_d = hi_in;
            acc_lo_d = lo_in;
`endif
            if (is_mt_op(op)) begin
              state_d = StWb;
              done_d  = 1'b1;
              wb_d    = 1'b1;
              hi_d    = (op == OpMthi) ? src_a : hi_in;
              lo_d    = (op == OpMthi) ? lo_in : src_a;
            end else if (is_mul_op(op)) begin
              state_d = StMul;
              cnt_d   = CntW'(MUL_CYCLES - 1);
            end else begin
              state_d = StDiv;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = (is_signed_op(op) && src_a[DW-1]) ? -src_a : src_a;
            end
          end
        end
        StMul: begin
          if (cnt_q == '0) begin
            state_d      = StWb;
            done_d       = 1'b1;
            wb_d         = 1'b1;
            {hi_d, lo_d} = mul_res;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDiv: begin
          if (cnt_q != CntW'(DW)) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Sign fix: remainder follows the dividend, quotient negated on sign mismatch.
            state_d = StWb;
            done_d  = 1'b1;
            wb_d    = 1'b1;
            hi_d    = a_neg ? -rem_q : rem_q;
            lo_d    = (a_neg ^ b_neg) ? -quo_q : quo_q;
          end
        end
        StWb: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wb_q    <= 1'b0;
`ifdef MDU_MADD_EN
      acc_hi_q <= '0;
      acc_lo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wb_q    <= wb_d;
`ifdef MDU_MADD_EN
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: directed corner cases plus random ops against an arithmetic model.
// Honours MDU_MADD_EN the same way as the design.
module tb_hilo_mdu_ctrl;

  localparam int MULC = 2;

  logic        clk, rst, start, flush;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, hi_in, lo_in;
  logic        busy, done, hilo_we;
  logic [31:0] hi_o, lo_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  hilo_mdu_ctrl #(
    .DATA_WIDTH(32),
    .MUL_CYCLES(MULC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .flush(flush),
    .src_a(src_a),
    .src_b(src_b),
    .hi_in(hi_in),
    .lo_in(lo_in),
    .busy(busy),
    .done(done),
    .hilo_we(hilo_we),
    .hi_o(hi_o),
    .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result, completion cycle and stall class straight from the arithmetic rules.
  task automatic model(input logic [3:0] o, input logic [31:0] a, b, hi, lo,
                       output logic [31:0] eh, el, output int n, output bit bcls,
                       output bit wr);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    eh = '0; el = '0; n = 0; bcls = 0; wr = 0; p = '0;
    case (o)
      4'd1, 4'd2: begin
        if (o == 4'd1) p = sa * sb;
        else p = {32'd0, a} * {32'd0, b};
        {eh, el} = p; n = MULC + 1; bcls = 1; wr = 1;
      end
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: begin
        if (o == 4'd7 || o == 4'd9) p = sa * sb;
        else p = {32'd0, a} * {32'd0, b};
        if (o <= 4'd8) {eh, el} = {hi, lo} + p;
        else {eh, el} = {hi, lo} - p;
        n = MULC + 1; bcls = 1; wr = 1;
      end
`endif
      4'd3: begin
        if (b == 0) begin
          el = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          eh = a;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          el = 32'(sq);
          eh = 32'(sr);
        end
        n = 34; bcls = 1; wr = 1;
      end
      4'd4: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
        n = 34; bcls = 1; wr = 1;
      end
      4'd5: begin eh = a;  el = lo; n = 1; wr = 1; end
      4'd6: begin eh = hi; el = a;  n = 1; wr = 1; end
      default: ;
    endcase
  endtask

  // Issue in the current cycle (cycle 0), then follow the op cycle by cycle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, b, hi, lo);
    logic [31:0] eh, el;
    int          n, limit;
    bit          bcls, wr;
    model(o, a, b, hi, lo, eh, el, n, bcls, wr);
    start = 1'b1; op = o; src_a = a; src_b = b; hi_in = hi; lo_in = lo;
    #1;
    chk("busy_issue", busy, bcls);
    chk("we_issue", hilo_we, 0);
    @(posedge clk); #1;
    limit = wr ? n + 1 : 4;
    for (int k = 1; k <= limit; k++) begin
      // Operands and start wiggle while the op is in flight; none of it may be taken.
      start = wr && (k <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
      op    = 4'($urandom_range(1, 6));
      src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
      #1;
      chk("busy", busy, bcls && (k < n));
      chk("hilo_we", hilo_we, wr && (k == n));
      chk("done", done, wr && (k == n));
      if (wr && k == n) begin
        chk("hi_o", hi_o, eh);
        chk("lo_o", lo_o, el);
      end
      @(posedge clk); #1;
    end
    if (wr) begin
      mdl_hi = eh;
      mdl_lo = el;
    end
    chk("hi_hold", hi_o, mdl_hi);
    chk("lo_hold", lo_o, mdl_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 9));
      1: return $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      2: return -32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    src_a = '0; src_b = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_we", hilo_we, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi_o, 0);
      chk("rst_lo", lo_o, 0);
    end

    run_op(4'd1, 32'hFFFF_FFFF, 32'h2, '0, '0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'h2, '0, '0);
    run_op(4'd3, -32'd7, 32'd2, '0, '0);
    run_op(4'd4, 32'd7, 32'd0, '0, '0);
    run_op(4'd6, 32'h1234_5678, 32'h0, 32'hAAAA_0000, 32'h5555_1111);
    run_op(4'd5, 32'hCAFE_F00D, 32'h0, 32'h1111_2222, 32'h3333_4444);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
    run_op(4'd3, -32'd9, 32'd0, '0, '0);
    run_op(4'd8, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF);
    run_op(4'd0, 32'd5, 32'd6, '0, '0);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, '0, '0);

    // Flush a divide at cycle 10, then a MULT issued at cycle 11 finishes at cycle 14.
    start = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd7;
    #1 chk("fl_busy0", busy, 1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      flush = (k == 10);
      #1;
      chk("fl_busy", busy, 1);
      chk("fl_we", hilo_we, 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    #1;
    chk("fl_idle_busy", busy, 0);
    chk("fl_idle_we", hilo_we, 0);
    chk("fl_hi", hi_o, mdl_hi);
    run_op(4'd1, 32'd3, -32'd5, '0, '0);

    // Reset in the middle of a divide: no write, outputs cleared.
    start = 1'b1; op = 4'd4; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      rst = (k == 4);
      #1;
      chk("rs_we", hilo_we, 0);
      chk("rs_busy", busy, k <= 4);
      @(posedge clk); #1;
    end
    mdl_hi = '0;
    mdl_lo = '0;
    chk("rs_hi", hi_o, mdl_hi);
    chk("rs_lo", lo_o, mdl_lo);

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
